// File: rtl/unidad_riesgos_cortocircuito.sv
// unidad_riesgos_cortocircuito
// Hazard controller for the 5-stage MIPS pipeline. It tracks the destination
// registers of the instructions in EX and MEM. It registers the forwarding
// selects for both ALU operands, which are valid during the EX cycle of each
// instruction. It also detects load-use hazards, stalls IF/ID for one cycle and
// puts a bubble into EX.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_Enable              debug step/run enable; 0 holds all state
//   i_ID_*                decoded source/destination info of the ID instruction
//   o_Stall               combinational: hold PC and IF/ID, load a bubble into ID/EX
//   o_EX_CortocircuitoA/B registered operand selects (000 reg, 001 EX/MEM, 010 MEM/WR)
//   o_ContadorStalls      stall cycles since reset (wraps)
module unidad_riesgos_cortocircuito #(
  parameter int unsigned REGS          = 5,
  parameter int unsigned CORTOCIRCUITO = 3,
  parameter int unsigned NBITS         = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_Enable,
  input  logic                     i_ID_Valid,
  input  logic [REGS-1:0]          i_ID_Rs,
  input  logic [REGS-1:0]          i_ID_Rt,
  input  logic                     i_ID_UsaRt,
  input  logic [REGS-1:0]          i_ID_RegDest,
  input  logic                     i_ID_RegWrite,
  input  logic                     i_ID_MemRead,
  output logic                     o_Stall,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortocircuitoA,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortocircuitoB,
  output logic [NBITS-1:0]         o_ContadorStalls
);

  localparam logic [CORTOCIRCUITO-1:0] SEL_REG   = CORTOCIRCUITO'(0);
  localparam logic [CORTOCIRCUITO-1:0] SEL_EXMEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] SEL_MEMWR = CORTOCIRCUITO'(2);

  typedef struct packed {
    logic            valid;
    logic [REGS-1:0] dest;
    logic            regwrite;
    logic            memread;
  } ex_rec_t;

  typedef struct packed {
    logic            valid;
    logic [REGS-1:0] dest;
    logic            regwrite;
  } mem_rec_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;

  logic                     ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
  logic                     ex_load_rs, ex_load_rt;
  logic                     bubble;
  logic [CORTOCIRCUITO-1:0] sel_a_d, sel_b_d;

  // Producer matches; register 0 never counts as written
  always_comb begin
    ex_wr_rs   = ex_q.valid & ex_q.regwrite & (ex_q.dest == i_ID_Rs) & (i_ID_Rs != '0);
    ex_wr_rt   = ex_q.valid & ex_q.regwrite & (ex_q.dest == i_ID_Rt) & (i_ID_Rt != '0);
    mem_wr_rs  = mem_q.valid & mem_q.regwrite & (mem_q.dest == i_ID_Rs) & (i_ID_Rs != '0);
    mem_wr_rt  = mem_q.valid & mem_q.regwrite & (mem_q.dest == i_ID_Rt) & (i_ID_Rt != '0);
    ex_load_rs = ex_wr_rs & ex_q.memread;
    ex_load_rt = ex_wr_rt & ex_q.memread & i_ID_UsaRt;
  end

  // Load-use stall; a load in EX is never a forwarding source
  always_comb begin
    o_Stall = 1'b0;
    if (!i_reset)
      o_Stall = i_ID_Valid & (ex_load_rs | ex_load_rt);
  end

  // Next forwarding selects; the youngest producer (EX) wins
  always_comb begin
    bubble  = o_Stall | ~i_ID_Valid;
    sel_a_d = SEL_REG;
    sel_b_d = SEL_REG;
    if (!bubble) begin
      if (ex_wr_rs)       sel_a_d = SEL_EXMEM;
      else if (mem_wr_rs) sel_a_d = SEL_MEMWR;
      if (i_ID_UsaRt) begin
        if (ex_wr_rt)       sel_b_d = SEL_EXMEM;
        else if (mem_wr_rt) sel_b_d = SEL_MEMWR;
      end
    end
  end

  // Pipeline records, selects and stall counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q                <= '0;
      mem_q               <= '0;
      o_EX_CortocircuitoA <= SEL_REG;
      o_EX_CortocircuitoB <= SEL_REG;
      o_ContadorStalls    <= '0;
    end else if (i_Enable) begin
      mem_q.valid    <= ex_q.valid;
      mem_q.dest     <= ex_q.dest;
      mem_q.regwrite <= ex_q.regwrite;
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q.valid    <= 1'b1;
        ex_q.dest     <= i_ID_RegDest;
        ex_q.regwrite <= i_ID_RegWrite;
        ex_q.memread  <= i_ID_MemRead;
      end
      o_EX_CortocircuitoA <= sel_a_d;
      o_EX_CortocircuitoB <= sel_b_d;
      if (o_Stall)
        o_ContadorStalls <= o_ContadorStalls + NBITS'(1);
    end
  end

endmodule
